regfile_writeback_queue: RTL
============================

// Module: regfile_writeback_queue
// PURPOSE
//   Writer-side front end of the KGP_RISC Register_File write port. Accepts register
//   writeback requests from the execute/memory stages over a valid/ready handshake,
//   buffers them in a small in-order FIFO, and drains one entry per cycle onto the
//   Register_File Write/WriteRegister/WriteData port. Optionally forwards pending
//   (not yet committed) data to the two read ports to cover write-to-read hazards.
// PARAMETERS
//   DEPTH    4    queue entries; power of two, 2..16
//   AW       5    register address width (32 registers)
//   DW       32   data width
// PORTS
//   clk            in   1       rising-edge clock
//   rst            in   1       asynchronous, active-low reset
//   in_valid       in   1       writeback request present
//   in_ready       out  1       queue can accept this cycle
//   in_reg         in   AW      destination register
//   in_data        in   DW      value to write
//   drain_en       in   1       1 = head may be committed this cycle; 0 = hold
//   flush          in   1       synchronous discard of all queued entries
//   Write          out  1       Register_File write enable
//   WriteRegister  out  AW      Register_File write address
//   WriteData      out  DW      Register_File write data
//   ReadRegister1  in   AW      read address being used on RF port 1 (bypass lookup)
//   ReadRegister2  in   AW      read address being used on RF port 2 (bypass lookup)
//   byp_hit1/2     out  1       pending write matches ReadRegister1/2
//   byp_data1/2    out  DW      newest pending data for that register
//   count          out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   - Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping mod DEPTH;
//     count tracks occupancy 0..DEPTH. full = (count==DEPTH), empty = (count==0).
//   - Push: in_valid & in_ready at rising edge -> entry written at wr_ptr, wr_ptr+1.
//     in_ready = !full & !flush (combinational). A full queue refuses pushes even if a
//     pop happens the same cycle.
//   - Pop: Write = !empty & drain_en; WriteRegister/WriteData = head entry (driven
//     combinationally; hold last head value, 0 after reset, when empty). On a rising
//     edge with Write=1 the RF commits and rd_ptr+1.
//   - Latency: request accepted at edge N into empty queue -> Write=1 throughout cycle
//     N+1 -> committed at edge N+1. Throughput 1 write/cycle.
//   - Simultaneous push+pop (not full): count unchanged, both pointers advance.
//   - Order: strictly FIFO; duplicate destinations are committed in arrival order
//     (no coalescing). Register 0 is not special-cased.
//   - drain_en=0: Write=0, entries held; pushes continue until full.
//   - flush=1 at an edge: count<=0, rd_ptr<=wr_ptr; any same-cycle push is dropped
//     (in_ready already 0); Write still reflects the head during that cycle and the
//     head IS committed if Write=1 (flush discards only non-committed entries).
//   - Reset (rst=0, any time, async): pointers=0, count=0, Write=0, WriteRegister=0,
//     WriteData=0, in_ready=1 once rst deasserted, byp_hit1/2=0, byp_data1/2=0.
//     Entries in flight are lost; no write reaches the RF after reset asserts.
// CONFIGURATION
//   REGFILE_WB_BYPASS_EN
//   - defined: byp_hitK=1 when any valid entry has reg==ReadRegisterK; byp_dataK =
//     data of the newest (closest to wr_ptr) such entry; purely combinational over
//     the current contents; reflects a head being committed this cycle.
//   - undefined: bypass comparators not built; byp_hit1/2 tied 0, byp_data1/2 tied 0.
// TESTING
//   1 Reset: rst=0 mid-queue with count=3 -> Write=0, count=0, all outputs 0
//     immediately; after rst=1, in_ready=1.
//   2 Single write: push (reg 21, 45) into empty queue, drain_en=1 -> Write=1,
//     WriteRegister=21, WriteData=45 next cycle; Register_File reads 45 from r21 after.
//   3 Fill/backpressure: drain_en=0, push 5 requests with DEPTH=4 -> 4 accepted,
//     in_ready=0, count=4; set drain_en=1 -> 4 writes on 4 consecutive cycles in order.
//   4 Flush: queue holds (23,69),(5,7),(6,8), drain_en=1, flush=1 one cycle -> only
//     (23,69) committed; count=0 after the edge; simultaneous push of (7,9) dropped.
//   5 Bypass (REGFILE_WB_BYPASS_EN): drain_en=0, push (23,69) then (23,45),
//     ReadRegister1=23 -> byp_hit1=1, byp_data1=45; ReadRegister2=5 -> byp_hit2=0.
//     Without the macro -> byp_hit1=0, byp_data1=0.
//   6 Wrap: 10 push/pop-concurrent cycles with distinct regs -> pointers wrap, count
//     stays 1, every request committed exactly once in order.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Purpose: in-order writeback FIFO in front of the Register_File write port, with optional read bypass (REGFILE_WB_BYPASS_EN).
// Latency: a request accepted at edge N into an empty queue drives Write during cycle N+1; sustains one commit per cycle.
// Backpressure: in_ready drops when full or during flush; drain_en=0 holds the head; a full queue refuses pushes even while popping.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic                     Write,
  output logic [AW-1:0]            WriteRegister,
  output logic [DW-1:0]            WriteData,
  input  logic [AW-1:0]            ReadRegister1,
  input  logic [AW-1:0]            ReadRegister2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data1,
  output logic [DW-1:0]            byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] reg_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] hold_reg;
  logic [DW-1:0] hold_data;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign Write    = !empty && drain_en;
  assign pop      = Write;

  // When empty the write port shows the last head that was presented, not stale storage.
  assign WriteRegister = empty ? hold_reg  : reg_mem[rd_ptr];
  assign WriteData     = empty ? hold_data : data_mem[rd_ptr];

  // Entry storage: written on accepted push; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= in_reg;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy tracking; flush discards everything not committed this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Track the current head so the write port can keep showing it once the queue drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg  <= '0;
      hold_data <= '0;
    end else if (!empty) begin
      hold_reg  <= reg_mem[rd_ptr];
      hold_data <= data_mem[rd_ptr];
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to newest so the newest matching pending entry wins; the head counts even while committing.
  always_comb begin
    logic [PW-1:0] idx;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (reg_mem[idx] == ReadRegister1) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_mem[idx];
        end
        if (reg_mem[idx] == ReadRegister2) begin
          byp_hit2  = 1'b1;
          byp_data2 = data_mem[idx];
        end
      end
    end
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{ReadRegister1, ReadRegister2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
